vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator; successor to the fixed 640x480 sync block.

---
 rtl/vga_timing_gen_if.sv | 20 ++
 rtl/vga_timing_gen.sv | 195 +++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-request bus between vga_timing_gen (master) and an external pixel source (slave).
interface vga_timing_gen_if;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_de;
  logic       frame_start;
  logic [7:0] in_r;
  logic [7:0] in_g;
  logic [7:0] in_b;

  modport master (
    output pix_x, pix_y, pix_de, frame_start,
    input  in_r, in_g, in_b
  );

  modport slave (
    input  pix_x, pix_y, pix_de, frame_start,
    output in_r, in_g, in_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator; sync/blank are delayed by PIX_LAT+1 to meet returned RGB.
// Optional feature macro: TEST_PATTERN_EN adds pat_sel and an 8-bar colour test pattern.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_LAT  = 2
) (
  input  logic              VGA_CLK,
  input  logic              reset,
  input  logic              en,
`ifdef TEST_PATTERN_EN
  input  logic              pat_sel,
`endif
  vga_timing_gen_if.master  pix,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  // 11-bit bounds so an active window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_SYNC_C  = 11'(H_SYNC);
  localparam logic [10:0] H_START_C = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END_C   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] H_LAST_C  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_SYNC_C  = 11'(V_SYNC);
  localparam logic [10:0] V_START_C = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_END_C   = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] V_LAST_C  = 11'(V_TOTAL - 1);

  localparam int HS_B = 0;
  localparam int VS_B = 1;
  localparam int DE_B = 2;
`ifdef TEST_PATTERN_EN
  localparam int DW = 6;
  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
  localparam logic [9:0] BAR_W_C = 10'(BAR_W);

  // Bar index bits map straight onto inverted colour channels: 0 = white ... 7 = black
  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
  endfunction
`else
  localparam int DW = 3;
`endif

  logic [9:0]    h_cnt_r;
  logic [9:0]    v_cnt_r;
  logic [10:0]   h_ext_s;
  logic [10:0]   v_ext_s;
  logic          h_last_s;
  logic          v_last_s;
  logic          de_s;
  logic [9:0]    px_s;
  logic [9:0]    py_s;
  logic [DW-1:0] st0_s;
  logic [DW-1:0] st0_r;
  logic [DW-1:0] dl_out_s;
  logic [9:0]    pix_x_r;
  logic [9:0]    pix_y_r;
  logic          frame_start_r;
  logic [23:0]   rgb_s;

  assign h_ext_s = {1'b0, h_cnt_r};
  assign v_ext_s = {1'b0, v_cnt_r};

  // Raster decode of the current counter position
  always_comb begin
    h_last_s = (h_ext_s == H_LAST_C);
    v_last_s = (v_ext_s == V_LAST_C);
    de_s     = (h_ext_s >= H_START_C) && (h_ext_s < H_END_C) &&
               (v_ext_s >= V_START_C) && (v_ext_s < V_END_C);
    px_s     = h_cnt_r - H_START_C[9:0];
    py_s     = v_cnt_r - V_START_C[9:0];
    st0_s    = {DW{1'b0}};
    st0_s[HS_B] = (h_ext_s < H_SYNC_C);
    st0_s[VS_B] = (v_ext_s < V_SYNC_C);
    st0_s[DE_B] = de_s;
`ifdef TEST_PATTERN_EN
    if ((px_s / BAR_W_C) > 10'd7) begin
      st0_s[5:3] = 3'd7;
    end else begin
      st0_s[5:3] = 3'((px_s / BAR_W_C));
    end
`endif
  end

  // Horizontal/vertical position counters
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (en) begin
      if (h_last_s) begin
        h_cnt_r <= 10'd0;
        v_cnt_r <= v_last_s ? 10'd0 : (v_cnt_r + 10'd1);
      end else begin
        h_cnt_r <= h_cnt_r + 10'd1;
      end
    end
  end

  // Stage 0: pixel request and raw sync/blank registered from the counters
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      pix_x_r       <= 10'd0;
      pix_y_r       <= 10'd0;
      frame_start_r <= 1'b0;
      st0_r         <= {DW{1'b0}};
    end else if (en) begin
      pix_x_r       <= de_s ? px_s : 10'd0;
      pix_y_r       <= de_s ? py_s : 10'd0;
      frame_start_r <= (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
      st0_r         <= st0_s;
    end
  end

  assign pix.pix_x       = pix_x_r;
  assign pix.pix_y       = pix_y_r;
  assign pix.pix_de      = st0_r[DE_B];
  assign pix.frame_start = frame_start_r;

  generate
    if (PIX_LAT == 0) begin : g_no_dl
      assign dl_out_s = st0_r;
    end else begin : g_dl
      logic [DW-1:0] dl_r [PIX_LAT];

      // Delay line matching the pixel source read latency
      always_ff @(posedge VGA_CLK or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < PIX_LAT; i++) begin
            dl_r[i] <= {DW{1'b0}};
          end
        end else if (en) begin
          dl_r[0] <= st0_r;
          for (int i = 1; i < PIX_LAT; i++) begin
            dl_r[i] <= dl_r[i-1];
          end
        end
      end

      assign dl_out_s = dl_r[PIX_LAT-1];
    end
  endgenerate

  // Colour select: blanked pixels are forced black
  always_comb begin
    rgb_s = 24'd0;
    if (dl_out_s[DE_B]) begin
`ifdef TEST_PATTERN_EN
      if (pat_sel) begin
        rgb_s = bar_rgb(dl_out_s[5:3]);
      end else begin
        rgb_s = {pix.in_r, pix.in_g, pix.in_b};
      end
`else
      rgb_s = {pix.in_r, pix.in_g, pix.in_b};
`endif
    end else begin
      rgb_s = 24'd0;
    end
  end

  // Final output register towards the DAC
  always_ff @(posedge VGA_CLK or negedge reset) begin
    if (!reset) begin
      VGA_R       <= 8'd0;
      VGA_G       <= 8'd0;
      VGA_B       <= 8'd0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
      VGA_BLANK_N <= 1'b0;
    end else if (en) begin
      {VGA_R, VGA_G, VGA_B} <= rgb_s;
      VGA_HS      <= dl_out_s[HS_B] ? HS_POL : ~HS_POL;
      VGA_VS      <= dl_out_s[VS_B] ? VS_POL : ~VS_POL;
      VGA_BLANK_N <= dl_out_s[DE_B];
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a reduced 25x11 raster with an arithmetic reference model.
module tb_vga_timing_gen;
  localparam int HSW = 4, HB = 3, HA = 16, HF = 2;
  localparam int VSW = 2, VB = 2, VA = 6, VF = 1;
  localparam int HT = HSW + HB + HA + HF;
  localparam int VT = VSW + VB + VA + VF;
  localparam int FT = HT * VT;
  localparam int LAT = 2;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b1;
  localparam int HA0 = HSW + HB;
  localparam int VA0 = VSW + VB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [7:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs, vga_bn;
`ifdef TEST_PATTERN_EN
  logic pat_sel = 1'b0;
`endif

  always #5 clk = ~clk;

  vga_timing_gen_if pif ();

  vga_timing_gen #(
    .H_SYNC(HSW), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VSW), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF),
    .HS_POL(HPOL), .VS_POL(VPOL), .PIX_LAT(LAT)
  ) dut (
    .VGA_CLK(clk),
    .reset(rst_n),
    .en(en),
`ifdef TEST_PATTERN_EN
    .pat_sel(pat_sel),
`endif
    .pix(pif),
    .VGA_R(vga_r),
    .VGA_G(vga_g),
    .VGA_B(vga_b),
    .VGA_HS(vga_hs),
    .VGA_VS(vga_vs),
    .VGA_BLANK_N(vga_bn)
  );

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    logic        de;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        bn;
    logic [23:0] rgb;
  } exp_t;

  typedef struct {
    int         n;
    logic       fs;
    logic       de;
    logic [9:0] px;
    logic       hs;
    logic       vs;
    logic       bn;
    logic [7:0] r;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int n = 0;
  bit use_pattern = 1'b0;
  logic [7:0] salt_g, salt_b;
  logic [23:0] sh [LAT];
  logic [23:0] bars [8];
  vec_t vecs [15];

  function automatic logic [23:0] src_color(input int x, input int y);
    logic [7:0] rr, gg, bb;
    rr = 8'(x);
    gg = 8'(y) ^ salt_g;
    bb = 8'(3 * x + y) ^ salt_b;
    return {rr, gg, bb};
  endfunction

  function automatic bit visible(input int h, input int v);
    return (h >= HA0) && (h < HA0 + HA) && (v >= VA0) && (v < VA0 + VA);
  endfunction

  // Expected outputs after `cnt` enabled edges since reset release
  function automatic exp_t model(input int cnt);
    exp_t e;
    int p, h, v, q, bar;
    e.px = 10'd0; e.py = 10'd0; e.de = 1'b0; e.fs = 1'b0;
    e.hs = !HPOL; e.vs = !VPOL; e.bn = 1'b0; e.rgb = 24'd0;
    if (cnt >= 1) begin
      p = (cnt - 1) % FT;
      h = p % HT;
      v = p / HT;
      e.de = visible(h, v);
      if (e.de) begin
        e.px = 10'(h - HA0);
        e.py = 10'(v - VA0);
      end
      e.fs = (p == 0);
    end
    if (cnt - LAT - 2 >= 0) begin
      q = (cnt - LAT - 2) % FT;
      h = q % HT;
      v = q / HT;
      e.hs = (h < HSW) ? HPOL : !HPOL;
      e.vs = (v < VSW) ? VPOL : !VPOL;
      e.bn = visible(h, v);
      if (e.bn) begin
        bar = (h - HA0) / (HA / 8);
        if (bar > 7) bar = 7;
        e.rgb = use_pattern ? bars[bar] : src_color(h - HA0, v - VA0);
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s n=%0d actual=%0h required=%0h", name, n, act, req);
    end
  endtask

  task automatic cmp_all();
    exp_t e;
    e = model(n);
    chk("pix_x", 32'(pif.pix_x), 32'(e.px));
    chk("pix_y", 32'(pif.pix_y), 32'(e.py));
    chk("pix_de", 32'(pif.pix_de), 32'(e.de));
    chk("frame_start", 32'(pif.frame_start), 32'(e.fs));
    chk("vga_hs", 32'(vga_hs), 32'(e.hs));
    chk("vga_vs", 32'(vga_vs), 32'(e.vs));
    chk("blank_n", 32'(vga_bn), 32'(e.bn));
    chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
  endtask

  // One clock: advance model, play the pixel source, compare everything
  task automatic step();
    logic en_e;
    @(posedge clk);
    en_e = en && rst_n;
    if (!rst_n) n = 0;
    else if (en_e) n++;
    #1;
    if (en_e) begin
      {pif.in_r, pif.in_g, pif.in_b} = sh[LAT-1];
      for (int i = LAT - 1; i > 0; i--) sh[i] = sh[i-1];
      sh[0] = src_color(int'(pif.pix_x), int'(pif.pix_y));
    end
    cmp_all();
  endtask

  initial begin
    int cnt, guard;
    logic prev;
    bit found;

    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    salt_g = 8'($urandom_range(0, 255));
    salt_b = 8'($urandom_range(0, 255));
    for (int i = 0; i < LAT; i++) sh[i] = 24'd0;
    pif.in_r = 8'd0; pif.in_g = 8'd0; pif.in_b = 8'd0;

    //            n    fs    de    px     hs    vs    bn    r
    vecs[0]  = '{1,   1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{2,   1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{4,   1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{7,   1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{8,   1'b0, 1'b0, 10'd0, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{29,  1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{54,  1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{110, 1'b0, 1'b1, 10'd2, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{111, 1'b0, 1'b1, 10'd3, 1'b1, 1'b0, 1'b1, 8'd0};
    vecs[9]  = '{126, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 8'd15};
    vecs[10] = '{127, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{251, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b1, 8'd15};
    vecs[12] = '{261, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[13] = '{276, 1'b1, 1'b0, 10'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[14] = '{279, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 8'd0};

    // Reset state
    #12;
    cmp_all();
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;

    // Boundary positions from the hand-derived table
    for (int i = 0; i < 15; i++) begin
      guard = 0;
      while (n < vecs[i].n && guard < 1000) begin
        step();
        guard++;
      end
      chk("vec_fs", 32'(pif.frame_start), 32'(vecs[i].fs));
      chk("vec_de", 32'(pif.pix_de), 32'(vecs[i].de));
      chk("vec_px", 32'(pif.pix_x), 32'(vecs[i].px));
      chk("vec_hs", 32'(vga_hs), 32'(vecs[i].hs));
      chk("vec_vs", 32'(vga_vs), 32'(vecs[i].vs));
      chk("vec_bn", 32'(vga_bn), 32'(vecs[i].bn));
      chk("vec_r", 32'(vga_r), 32'(vecs[i].r));
    end

    // Visible pixel count over one full frame
    cnt = 0;
    for (int i = 0; i < FT; i++) begin
      step();
      if (vga_bn) cnt++;
    end
    chk("blank_cnt", 32'(cnt), 32'(HA * VA));

    // Line length stretched by a 5-cycle enable gap
    found = 1'b0;
    prev = vga_hs;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (prev && !vga_hs) found = 1'b1;
      prev = vga_hs;
    end
    chk("hs_fall_seen", 32'(found), 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin step(); cnt++; end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin step(); cnt++; end
    en = 1'b1;
    found = 1'b0;
    prev = vga_hs;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      cnt++;
      if (prev && !vga_hs) found = 1'b1;
      prev = vga_hs;
    end
    chk("line_len", 32'(cnt), 32'(HT + 5));

    // Random enable pattern against the model
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 3) != 0);
      step();
    end
    en = 1'b1;

    // Asynchronous reset mid-frame, then restart
    found = 1'b0;
    for (int i = 0; i < 2 * FT && !found; i++) begin
      step();
      if (n >= 1 && (n - 1) % FT == 6 * HT + 12) found = 1'b1;
    end
    chk("rst_seek", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    n = 0;
    cmp_all();
    for (int i = 0; i < 3; i++) step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("fs_after_rst", 32'(pif.frame_start), 32'd1);
    for (int i = 0; i < 300; i++) step();

`ifdef TEST_PATTERN_EN
    // Colour bars through the same latency path
    pat_sel = 1'b1;
    use_pattern = 1'b1;
    for (int i = 0; i < FT + 10; i++) step();
    pat_sel = 1'b0;
    use_pattern = 1'b0;
    for (int i = 0; i < 20; i++) step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
